seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_mul_pkg.sv | 8 +
 rtl/seq_mul_if.sv | 18 +
 rtl/seq_mul_ctrl.sv | 60 ++++++
 rtl/seq_multiplier.sv | 58 +++++
 tb/tb_seq_multiplier.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM state type and default operand width for the sequential multiplier
package seq_mul_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

endpackage

// File: rtl/seq_mul_if.sv
// seq_mul_if: request/result bundle between a multiplier client (master) and the multiplier (slave)
interface seq_mul_if
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);

endinterface

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: IDLE/CALC/DONE sequencer, bit counter and load/shift strobes.
// With SEQ_MUL_EARLY_EXIT_EN defined, CALC also ends once the remaining multiplier bits are zero.
module seq_mul_ctrl
    import seq_mul_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          b_zero,
    input  logic          cnt_last,
    output logic          load,
    output logic          shift,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] cnt
);

    state_t state;
    logic   fin;

    assign load  = start && state != CALC;
    assign shift = state == CALC;

`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign fin = cnt_last || b_zero;
`else
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
    assign fin = cnt_last;
`endif

    // Sequencer with registered busy/done so start never reaches an output combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (load) begin
            state <= CALC;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (state == CALC) begin
            cnt <= cnt + 1'b1;
            if (fin) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add unsigned multiplier, one multiplier bit per cycle.
// Define SEQ_MUL_EARLY_EXIT_EN to stop as soon as the remaining multiplier bits are zero.
module seq_multiplier
    import seq_mul_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst_n,
    seq_mul_if.slave bus
);

    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] p_reg;
    logic [2*WIDTH-1:0] addend;
    logic [CW-1:0]      cnt;
    logic               load;
    logic               shift;
    logic               b_zero;
    logic               cnt_last;

    assign addend      = b_reg[0] ? ({{WIDTH{1'b0}}, a_reg} << cnt) : '0;
    assign b_zero      = b_reg[WIDTH-1:1] == '0;
    assign cnt_last    = cnt == CW'(WIDTH - 1);
    assign bus.product = p_reg;

    seq_mul_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (bus.start),
        .b_zero   (b_zero),
        .cnt_last (cnt_last),
        .load     (load),
        .shift    (shift),
        .busy     (bus.busy),
        .done     (bus.done),
        .cnt      (cnt)
    );

    // Operand capture on accept, then accumulate the shifted multiplicand per multiplier bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            p_reg <= '0;
        end else if (load) begin
            a_reg <= bus.a;
            b_reg <= bus.b;
            p_reg <= '0;
        end else if (shift) begin
            p_reg <= p_reg + addend;
            b_reg <= b_reg >> 1;
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of products, latency, start handling and async reset
module tb_seq_multiplier;

    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    seq_mul_if #(.WIDTH(W)) bus ();

    seq_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Edges from the accepting edge (counted as 1) to the edge after which done is seen
    function automatic int lat(input logic [7:0] b);
`ifdef SEQ_MUL_EARLY_EXIT_EN
        int n = 1;
        for (int i = 0; i < 8; i++) if (b[i]) n = i + 1;
        return n + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] x, input logic [7:0] y);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (bus.done !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    task automatic mul(input string tag, input logic [7:0] x, input logic [7:0] y, input logic [15:0] p);
        int n;
        go(x, y);
        check({tag, " busy"}, 32'(bus.busy), 1);
        wait_done(n);
        check({tag, " latency"}, n, lat(y));
        check({tag, " product"}, 32'(bus.product), 32'(p));
        tick();
        check({tag, " done drop"}, 32'(bus.done), 0);
        tick();
        check({tag, " hold"}, 32'(bus.product), 32'(p));
    endtask

    initial begin
        int n;
        int pulses;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        #12;
        check("reset product", 32'(bus.product), 0);
        check("reset busy", 32'(bus.busy), 0);
        check("reset done", 32'(bus.done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        mul("13x11", 8'd13, 8'd11, 16'd143);
        mul("255x255", 8'd255, 8'd255, 16'd65025);
        mul("77x0", 8'd77, 8'd0, 16'd0);
        mul("0x200", 8'd0, 8'd200, 16'd0);
        mul("1x128", 8'd1, 8'd128, 16'd128);

        // start pulsed mid-CALC must be ignored
        go(8'd13, 8'd11);
        tick();
        tick();
        bus.start = 1'b1;
        bus.a     = 8'd2;
        bus.b     = 8'd3;
        tick();
        bus.start = 1'b0;
        check("ignore busy", 32'(bus.busy), 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        check("ignore pulses", pulses, 1);
        check("ignore product", 32'(bus.product), 143);

        // back-to-back start held in DONE
        go(8'd13, 8'd11);
        wait_done(n);
        check("b2b first latency", n, lat(8'd11));
        check("b2b first product", 32'(bus.product), 143);
        bus.start = 1'b1;
        bus.a     = 8'd7;
        bus.b     = 8'd6;
        tick();
        bus.start = 1'b0;
        check("b2b restart busy", 32'(bus.busy), 1);
        check("b2b restart done", 32'(bus.done), 0);
        check("b2b cleared", 32'(bus.product), 0);
        wait_done(n);
        check("b2b second latency", n, lat(8'd6));
        check("b2b second product", 32'(bus.product), 42);
        tick();
        tick();

        // asynchronous reset mid-CALC aborts with no done
        go(8'd13, 8'd11);
        tick();
        tick();
        check("abort busy", 32'(bus.busy), 1);
        check("abort partial", 32'(bus.product), 39);
        #2 rst_n = 1'b0;
        #1;
        check("abort product", 32'(bus.product), 0);
        check("abort busy low", 32'(bus.busy), 0);
        check("abort done low", 32'(bus.done), 0);
        #10 rst_n = 1'b1;
        tick();
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            if (bus.done === 1'b1) pulses++;
            tick();
        end
        check("abort no done", pulses, 0);
        mul("3x5", 8'd3, 8'd5, 16'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
